// File: rtl/mmio_out_port_bank.sv
// Multi-channel MMIO output port: CPU writes are buffered per channel in a FWFT FIFO and
// drained through valid/ready streams. Define MMIO_OUT_NONBLOCK_EN to drop (and flag) writes to a full FIFO.
module mmio_out_port_bank #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] ADDR_BASE = 32'h1000_0000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

`ifdef MMIO_OUT_NONBLOCK_EN
    typedef enum logic [1:0] {StIdle, StAck} state_e;
`else
    typedef enum logic [1:0] {StIdle, StAck, StStall} state_e;
`endif

    state_e              state_q;
    logic [PW-1:0]       wr_ptr_q [NUM_CH];
    logic [PW-1:0]       rd_ptr_q [NUM_CH];
    logic [CW-1:0]       count_q  [NUM_CH];
    logic [DATA_W-1:0]   mem_q    [NUM_CH][DEPTH];

    logic                sel, accept, is_write, is_data_off;
    logic [7:0]          offset;
    logic [3:0]          req_ch;
    logic [NUM_CH-1:0]   req_sel, full, empty, push, pop;
    logic [DATA_W-1:0]   push_data;
    logic [31:0]         rd_val;
    logic                unused_wdata;

    assign sel         = mem_valid && (mem_addr[31:8] == ADDR_BASE[31:8]);
    assign accept      = (state_q == StIdle) && sel && !mem_ready;
    assign is_write    = |mem_wstrb;
    assign offset      = mem_addr[7:0];
    assign req_ch      = offset[5:2];
    assign is_data_off = (offset[7:6] == 2'b00) && (offset[1:0] == 2'b00);
    assign pop         = out_valid & out_ready;
    assign unused_wdata = ^mem_wdata;

    always_comb begin
        req_sel  = '0;
        full     = '0;
        empty    = '0;
        out_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_sel[i] = is_data_off && (32'(req_ch) == i);
            full[i]    = (count_q[i] == CW'(DEPTH));
            empty[i]   = (count_q[i] == '0);
            // Head is gated so out_data reads 0 while empty, independent of stale storage.
            if (!empty[i]) out_data[i*DATA_W +: DATA_W] = mem_q[i][rd_ptr_q[i]];
        end
    end

    assign out_valid = ~empty;

`ifdef MMIO_OUT_NONBLOCK_EN
    logic [NUM_CH-1:0] ovf_q, ovf_set, ovf_clr;
    logic              is_ovf;

    assign is_ovf  = (offset == 8'h44);
    assign ovf_set = (accept && is_write) ? (req_sel & full) : '0;
    assign ovf_clr = (accept && is_write && is_ovf) ? mem_wdata[NUM_CH-1:0] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ovf_q <= '0;
        else         ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
    end
`else
    logic [NUM_CH-1:0] stall_sel_q;
    logic [DATA_W-1:0] stall_data_q;
`endif

    always_comb begin
        push      = '0;
        push_data = mem_wdata[DATA_W-1:0];
        if (accept && is_write && ((req_sel & full) == '0)) push = req_sel;
`ifndef MMIO_OUT_NONBLOCK_EN
        // A pop on the same edge frees the slot, so a full FIFO can still take the stalled write.
        if (state_q == StStall) begin
            push_data = stall_data_q;
            if ((stall_sel_q & full & ~pop) == '0) push = stall_sel_q;
        end
`endif
    end

    always_comb begin
        rd_val = '0;
        if (offset == 8'h40) begin
            rd_val[NUM_CH-1:0]    = empty;
            rd_val[16 +: NUM_CH]  = full;
        end
`ifdef MMIO_OUT_NONBLOCK_EN
        if (is_ovf) rd_val[NUM_CH-1:0] = ovf_q;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
`ifndef MMIO_OUT_NONBLOCK_EN
            stall_sel_q  <= '0;
            stall_data_q <= '0;
`endif
        end else begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
`ifndef MMIO_OUT_NONBLOCK_EN
                        if (is_write && ((req_sel & full) != '0)) begin
                            state_q      <= StStall;
                            stall_sel_q  <= req_sel;
                            stall_data_q <= mem_wdata[DATA_W-1:0];
                        end else
`endif
                        begin
                            state_q   <= StAck;
                            mem_ready <= 1'b1;
                            mem_rdata <= is_write ? 32'h0 : rd_val;
                        end
                    end
                end
`ifndef MMIO_OUT_NONBLOCK_EN
                StStall: begin
                    if (push != '0) begin
                        state_q   <= StAck;
                        mem_ready <= 1'b1;
                    end
                end
`endif
                StAck:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
                else if (!push[i] && pop[i]) count_q[i] <= count_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= push_data;
        end
    end

endmodule

// File: tb/tb_mmio_out_port_bank.sv
// Directed self-checking bench for mmio_out_port_bank (NUM_CH=2, DATA_W=8, DEPTH=4).
module tb_mmio_out_port_bank;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] out_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready = '0;

    int n_checks = 0;
    int n_err = 0;

    mmio_out_port_bank #(
        .NUM_CH(2), .DATA_W(8), .DEPTH(4), .ADDR_BASE(32'h1000_0000)
    ) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus transaction with a bounded wait; lat is cycles until mem_ready (9 = never).
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       output int lat, output logic [31:0] rdata);
        int n = 0;
        logic got = 1'b0;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        rdata = '0;
        while (n < 8 && !got) begin
            @(posedge clk); #1; n++;
            if (mem_ready) begin got = 1'b1; rdata = mem_rdata; end
        end
        lat = got ? n : 9;
        mem_valid = 1'b0; mem_wstrb = '0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input string tag);
        int lat;
        logic [31:0] r;
        bus(BASE + {24'h0, off}, d, 4'hF, lat, r);
        check({tag, "_lat"}, 32'(lat), 32'd1);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
        int lat;
        logic [31:0] r;
        bus(BASE + {24'h0, off}, 32'h0, 4'h0, lat, r);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check(tag, r, exp);
    endtask

    task automatic pop_expect(input int ch, input logic [7:0] exp, input string tag);
        check({tag, "_valid"}, 32'(out_valid[ch]), 32'd1);
        check(tag, 32'(out_data[ch*8 +: 8]), 32'(exp));
        out_ready[ch] = 1'b1;
        @(posedge clk); #1;
        out_ready[ch] = 1'b0;
    endtask

    initial begin
        logic seen;

        // 1: reset state and first STATUS read
        #1;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        rd(8'h40, 32'h0000_0003, "status_reset");

        // 2: single push on channel 1
        wr(8'h04, 32'h0000_00A5, "wr_ch1");
        check("ch1_valid", 32'(out_valid), 32'h2);
        check("ch1_data", 32'(out_data[15:8]), 32'hA5);
        rd(8'h40, 32'h0000_0001, "status_ch1");
        pop_expect(1, 8'hA5, "ch1_pop");
        check("ch1_empty", 32'(out_valid), 32'h0);

        // Decode corners: unmapped channel, DATA read, other offset, OVF without the option
        wr(8'h08, 32'h11, "wr_unmapped");
        check("unmapped_novalid", 32'(out_valid), 32'h0);
        wr(8'h80, 32'h22, "wr_other");
        rd(8'h80, 32'h0, "rd_other");
`ifndef MMIO_OUT_NONBLOCK_EN
        rd(8'h44, 32'h0, "rd_ovf_off");
`endif

        // 3: fill and drain ch0 twice to exercise pointer wrap
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) wr(8'h00, 32'(b*16 + k + 1), "fill0");
            rd(8'h40, 32'h0001_0002, "status_full0");
            for (int k = 0; k < 4; k++) pop_expect(0, 8'(b*16 + k + 1), "drain0");
            check("drain0_empty", 32'(out_valid), 32'h0);
        end
        rd(8'h00, 32'h0, "rd_data0");

`ifndef MMIO_OUT_NONBLOCK_EN
        // 4: blocking write to a full FIFO stalls until one drain cycle
        for (int k = 0; k < 4; k++) wr(8'h00, 32'(k + 1), "fill_stall");
        mem_valid = 1'b1; mem_addr = BASE; mem_wdata = 32'h55; mem_wstrb = 4'hF;
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (mem_ready) seen = 1'b1; end
        check("stall_noack", 32'(seen), 32'd0);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("stall_ack", 32'(mem_ready), 32'd1);
        mem_valid = 1'b0; mem_wstrb = '0;
        @(posedge clk); #1;
        rd(8'h40, 32'h0001_0002, "status_after_stall");
        pop_expect(0, 8'h02, "stall_d0");
        pop_expect(0, 8'h03, "stall_d1");
        pop_expect(0, 8'h04, "stall_d2");
        pop_expect(0, 8'h55, "stall_d3");
        check("stall_empty", 32'(out_valid), 32'h0);
`else
        // 5: non-blocking overflow discards data and sets the sticky flag
        for (int k = 0; k < 4; k++) wr(8'h00, 32'(k + 1), "fill_ovf");
        wr(8'h00, 32'h77, "wr_ovf");
        rd(8'h44, 32'h1, "ovf_set");
        for (int k = 0; k < 4; k++) pop_expect(0, 8'(k + 1), "ovf_drain");
        check("ovf_empty", 32'(out_valid), 32'h0);
        wr(8'h44, 32'h1, "ovf_w1c");
        rd(8'h44, 32'h0, "ovf_clr");
`endif

        // 6: asynchronous reset with FIFOs partly full and a request in flight
        wr(8'h04, 32'h3C, "pre_rst1");
        for (int k = 0; k < 4; k++) wr(8'h00, 32'(k + 1), "pre_rst0");
        mem_valid = 1'b1; mem_addr = BASE; mem_wdata = 32'hCC; mem_wstrb = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("arst_ready", 32'(mem_ready), 32'd0);
        check("arst_rdata", mem_rdata, 32'h0);
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_data", 32'(out_data), 32'h0);
        mem_valid = 1'b0; mem_wstrb = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        wr(8'h00, 32'h99, "post_rst_wr");
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_data", 32'(out_data), 32'h0099);

        // Out-of-window request must never be acknowledged nor push
        mem_valid = 1'b1; mem_addr = 32'h2000_0000; mem_wdata = 32'hEE; mem_wstrb = 4'hF;
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (mem_ready) seen = 1'b1; end
        mem_valid = 1'b0; mem_wstrb = '0;
        check("foreign_noack", 32'(seen), 32'd0);
        check("foreign_nopush", 32'(out_data), 32'h0099);
        rd(8'h40, 32'h0000_0002, "status_final");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
